// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo
// Captures the ADC conversion result at the end of every RD low window and
// queues it in a small show-ahead FIFO. The consumer drains it via valid/ready.
// Fill level, a sticky overflow flag and a capture counter are exported for debug.
module adc_sample_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              CS,
  input  logic              RD,
  input  logic [DATA_W-1:0] D,
  input  logic              enable,
  input  logic              clr_ovf,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic [15:0]       sample_count
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_LEVEL  = (AW + 1)'(1);

  // Strobe tracking: delayed RD and the data latched during the RD-low window
  logic              rd_q_reg;
  logic [DATA_W-1:0] d_q_reg;
  logic [DATA_W-1:0] d_q_next;

  // FIFO state
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     wr_ptr_next;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW-1:0]     rd_ptr_next;
  logic [AW-1:0]     rd_ptr_plus1;
  logic [AW:0]       level_reg;
  logic [AW:0]       level_next;
  logic [DATA_W-1:0] m_data_reg;
  logic [DATA_W-1:0] m_data_next;
  logic              overflow_reg;
  logic              overflow_next;
  logic [15:0]       count_reg;
  logic [15:0]       count_next;

  // Event decode
  logic cap;
  logic full;
  logic empty;
  logic pop;
  logic push_ok;
  logic drop;

  assign full    = (level_reg == FULL_LEVEL);
  assign empty   = (level_reg == '0);
  // Rising edge of RD while the chip is selected ends a conversion read
  assign cap     = ~rd_q_reg & RD & ~CS & enable;
  assign pop     = ~empty & m_ready;
  // A full FIFO still accepts a sample when a slot frees in the same cycle
  assign push_ok = cap & (~full | pop);
  assign drop    = cap & full & ~pop;

  assign rd_ptr_plus1 = rd_ptr_reg + AW'(1);

  // Next-state logic for pointers, level, head register, flags and counter
  always_comb begin
    d_q_next      = d_q_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    level_next    = level_reg;
    m_data_next   = m_data_reg;
    overflow_next = overflow_reg;
    count_next    = count_reg;

    // Track D for as long as the read strobe is active, so the last RD-low
    // cycle's value is what gets captured
    if (!RD && !CS) begin
      d_q_next = D;
    end

    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_plus1;
    end

    case ({push_ok, pop})
      2'b10:   level_next = level_reg + ONE_LEVEL;
      2'b01:   level_next = level_reg - ONE_LEVEL;
      default: level_next = level_reg;
    endcase

    // Show-ahead head register: reload with the following entry on pop; when
    // the only entry leaves while a new one arrives, the new sample is not in
    // memory yet, so forward it directly
    if (pop) begin
      if (level_reg > ONE_LEVEL) begin
        m_data_next = mem[rd_ptr_plus1];
      end else if (push_ok) begin
        m_data_next = d_q_reg;
      end
    end else if (push_ok && empty) begin
      m_data_next = d_q_reg;
    end

    // Set has priority over clear so a drop is never lost
    if (drop) begin
      overflow_next = 1'b1;
    end else if (clr_ovf) begin
      overflow_next = 1'b0;
    end

    // Counts every capture event, accepted or dropped; wraps naturally
    if (cap) begin
      count_next = count_reg + 16'd1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rd_q_reg     <= 1'b1;
      d_q_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      m_data_reg   <= '0;
      overflow_reg <= 1'b0;
      count_reg    <= '0;
    end else begin
      rd_q_reg     <= RD;
      d_q_reg      <= d_q_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      m_data_reg   <= m_data_next;
      overflow_reg <= overflow_next;
      count_reg    <= count_next;
    end
  end

  // Sample storage; contents are not reset
  always_ff @(posedge Clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= d_q_reg;
    end
  end

  assign m_valid      = ~empty;
  assign m_data       = m_data_reg;
  assign level        = level_reg;
  assign overflow     = overflow_reg;
  assign sample_count = count_reg;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed testbench for adc_sample_fifo.
module tb_adc_sample_fifo;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       CS = 1'b1;
  logic       RD = 1'b1;
  logic [7:0] D = 8'h00;
  logic       enable = 1'b1;
  logic       clr_ovf = 1'b0;
  logic       m_ready = 1'b0;
  logic       m_valid;
  logic [7:0] m_data;
  logic [4:0] level;
  logic       overflow;
  logic [15:0] sample_count;

  int n_checks = 0;
  int n_fail   = 0;

  adc_sample_fifo #(.DATA_W(8), .DEPTH(16), .AW(4)) dut (
    .Clk(Clk), .Rst(Rst), .CS(CS), .RD(RD), .D(D), .enable(enable),
    .clr_ovf(clr_ovf), .m_ready(m_ready), .m_valid(m_valid), .m_data(m_data),
    .level(level), .overflow(overflow), .sample_count(sample_count)
  );

  always #5 Clk = ~Clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Rst = 1'b0; RD = 1'b1; CS = 1'b1; D = 8'h00; enable = 1'b1;
    clr_ovf = 1'b0; m_ready = 1'b0;
    tick(); tick();
    Rst = 1'b1;
    tick();
  endtask

  // One RD strobe: nlow cycles low with D=data, then one cycle high (the capture cycle)
  task automatic rd_window(input logic [7:0] data, input logic cs, input int nlow,
                           input logic rdy_low, input logic rdy_rise, input logic clr_rise);
    CS = cs; D = data; RD = 1'b0; m_ready = rdy_low;
    for (int i = 0; i < nlow; i++) tick();
    RD = 1'b1; m_ready = rdy_rise; clr_ovf = clr_rise;
    tick();
    m_ready = 1'b0; clr_ovf = 1'b0; CS = 1'b1;
    $display("window d=%02h cs=%0b en=%0b -> level=%0d count=%0d ovf=%0b",
             data, cs, enable, level, sample_count, overflow);
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    tick(); tick();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data got %02h want 00", m_data); end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    n_checks++; if (sample_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", sample_count); end
    Rst = 1'b1;
    tick();
  endtask

  task automatic test_single_capture();
    apply_reset();
    rd_window(8'hA5, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", m_valid); end
    n_checks++; if (m_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got %02h want a5", m_data); end
    n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL single_level got %0d want 1", level); end
    n_checks++; if (sample_count !== 16'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", sample_count); end
    pop_one();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid got %0b want 0", m_valid); end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL single_pop_level got %0d want 0", level); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 16; i++) rd_window(8'(i), 1'b0, 2, 1'b0, 1'b0, 1'b0);
    n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL ovf_full_level got %0d want 16", level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_full_flag got %0b want 0", overflow); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL ovf_head_stable got %02h want 00", m_data); end
    rd_window(8'h10, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL ovf_drop_level got %0d want 16", level); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_drop_flag got %0b want 1", overflow); end
    n_checks++; if (sample_count !== 16'd17) begin n_fail++; $display("FAIL ovf_count got %0d want 17", sample_count); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        n_fail++; $display("FAIL ovf_drain[%0d] got v=%0b d=%02h want v=1 d=%02h", i, m_valid, m_data, 8'(i));
      end
      pop_one();
    end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained_valid got %0b want 0", m_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_d;
    apply_reset();
    for (int i = 0; i < 16; i++) rd_window(8'(i), 1'b0, 2, 1'b0, 1'b0, 1'b0);
    rd_window(8'h55, 1'b0, 2, 1'b0, 1'b1, 1'b0);
    n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL fpp_level got %0d want 16", level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow got %0b want 0", overflow); end
    n_checks++; if (m_data !== 8'h01) begin n_fail++; $display("FAIL fpp_head got %02h want 01", m_data); end
    for (int i = 1; i <= 16; i++) begin
      exp_d = (i == 16) ? 8'h55 : 8'(i);
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== exp_d) begin
        n_fail++; $display("FAIL fpp_drain[%0d] got v=%0b d=%02h want v=1 d=%02h", i, m_valid, m_data, exp_d);
      end
      pop_one();
    end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL fpp_drained_level got %0d want 0", level); end
  endtask

  task automatic test_enable_cs();
    apply_reset();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) rd_window(8'h30 + 8'(i), 1'b0, 3, 1'b0, 1'b0, 1'b0);
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL en_level got %0d want 0", level); end
    n_checks++; if (sample_count !== 16'd0) begin n_fail++; $display("FAIL en_count got %0d want 0", sample_count); end
    enable = 1'b1;
    rd_window(8'h77, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL cs_valid got %0b want 0", m_valid); end
    n_checks++; if (sample_count !== 16'd0) begin n_fail++; $display("FAIL cs_count got %0d want 0", sample_count); end
  endtask

  task automatic test_clr_ovf();
    apply_reset();
    for (int i = 0; i < 17; i++) rd_window(8'(i), 1'b0, 2, 1'b0, 1'b0, 1'b0);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_pre got %0b want 1", overflow); end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_clear got %0b want 0", overflow); end
    rd_window(8'hEE, 1'b0, 2, 1'b0, 1'b0, 1'b1);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_set_wins got %0b want 1", overflow); end
    n_checks++; if (sample_count !== 16'd18) begin n_fail++; $display("FAIL clr_count got %0d want 18", sample_count); end
  endtask

  task automatic test_reset_and_wrap();
    int max_level;
    apply_reset();
    for (int i = 0; i < 5; i++) rd_window(8'h40 + 8'(i), 1'b0, 2, 1'b0, 1'b0, 1'b0);
    n_checks++; if (level !== 5'd5) begin n_fail++; $display("FAIL mid_pre_level got %0d want 5", level); end
    Rst = 1'b0;
    #1;
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL mid_rst_level got %0d want 0", level); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %0b want 0", m_valid); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data got %02h want 00", m_data); end
    n_checks++; if (sample_count !== 16'd0) begin n_fail++; $display("FAIL mid_rst_count got %0d want 0", sample_count); end
    tick();
    Rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_post_valid got %0b want 0", m_valid); end
    max_level = 0;
    for (int i = 0; i < 40; i++) begin
      rd_window(8'h80 + 8'(i), 1'b0, 2, 1'b1, 1'b1, 1'b0);
      if (int'(level) > max_level) max_level = int'(level);
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 8'h80 + 8'(i) || level !== 5'd1) begin
        n_fail++; $display("FAIL wrap[%0d] got v=%0b d=%02h lvl=%0d want v=1 d=%02h lvl=1",
                           i, m_valid, m_data, level, 8'h80 + 8'(i));
      end
    end
    n_checks++; if (max_level > 1) begin n_fail++; $display("FAIL wrap_max_level got %0d want <=1", max_level); end
    n_checks++; if (sample_count !== 16'd40) begin n_fail++; $display("FAIL wrap_count got %0d want 40", sample_count); end
    pop_one();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_final_valid got %0b want 0", m_valid); end
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_overflow();
    test_full_push_pop();
    test_enable_cs();
    test_clr_ovf();
    test_reset_and_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
